// File: rtl/control_secuencia_suma.sv
// Coefficient-add sequencer: steps slot index at a prescaled rate and pulses one write enable per slot.
// Define CONTROL_SECUENCIA_AUTO_EN to repeat passes while inicio stays high.
module control_secuencia_suma #(
  parameter int SLOTS = 3,
  parameter int SEL_W = 2,
  parameter int DIV   = 666
) (
  input  logic             clk100MHz,
  input  logic             reset,
  input  logic             inicio,
  output logic [SEL_W-1:0] contador,
  output logic [SLOTS-1:0] we,
  output logic             tick,
  output logic             ocupado,
  output logic             listo
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, ESPERA, ESCRIBE, FIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic              tick_q, tick_d;
  logic [SEL_W-1:0]  contador_q, contador_d;
  logic [SLOTS-1:0]  we_q, we_d;
  logic              ocupado_q, ocupado_d;
  logic              listo_q, listo_d;

  // Free-running prescaler, independent of the sequencer state.
  always_comb begin
    tick_d = (pcnt_q == PW'(DIV - 1));
    pcnt_d = tick_d ? '0 : pcnt_q + PW'(1);
  end

  // Outputs are computed one cycle ahead so they register in step with the state.
  always_comb begin
    state_d    = state_q;
    contador_d = contador_q;
    we_d       = '0;
    ocupado_d  = ocupado_q;
    listo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        ocupado_d = 1'b0;
        if (inicio) begin
          state_d    = ESPERA;
          contador_d = '0;
          ocupado_d  = 1'b1;
        end
      end
      ESPERA: begin
        if (tick_q) begin
          state_d = ESCRIBE;
          we_d    = SLOTS'(1) << contador_q;
        end
      end
      ESCRIBE: begin
        if (contador_q == SEL_W'(SLOTS - 1)) begin
          state_d = FIN;
          listo_d = 1'b1;
        end else begin
          state_d    = ESPERA;
          contador_d = contador_q + SEL_W'(1);
        end
      end
      FIN: begin
        contador_d = '0;
`ifdef CONTROL_SECUENCIA_AUTO_EN
        if (inicio) begin
          state_d   = ESPERA;
          ocupado_d = 1'b1;
        end else begin
          state_d   = IDLE;
          ocupado_d = 1'b0;
        end
`else
        state_d   = IDLE;
        ocupado_d = 1'b0;
`endif
      end
      default: begin
        state_d    = IDLE;
        contador_d = '0;
        ocupado_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      tick_q     <= 1'b0;
      contador_q <= '0;
      we_q       <= '0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      tick_q     <= tick_d;
      contador_q <= contador_d;
      we_q       <= we_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
    end
  end

  assign contador = contador_q;
  assign we       = we_q;
  assign tick     = tick_q;
  assign ocupado  = ocupado_q;
  assign listo    = listo_q;

endmodule

// File: tb/tb_control_secuencia_suma.sv
// Directed bench for control_secuencia_suma with DIV=4, SLOTS=3; every output checked on every cycle.
module tb_control_secuencia_suma;

  localparam int SLOTS = 3;
  localparam int SEL_W = 2;
  localparam int DIV   = 4;

  logic             clk100MHz = 1'b0;
  logic             reset;
  logic             inicio;
  logic [SEL_W-1:0] contador;
  logic [SLOTS-1:0] we;
  logic             tick;
  logic             ocupado;
  logic             listo;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int base   = 0;

  control_secuencia_suma #(.SLOTS(SLOTS), .SEL_W(SEL_W), .DIV(DIV)) dut (
    .clk100MHz (clk100MHz),
    .reset     (reset),
    .inicio    (inicio),
    .contador  (contador),
    .we        (we),
    .tick      (tick),
    .ocupado   (ocupado),
    .listo     (listo)
  );

  always #5 clk100MHz = ~clk100MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // One clock edge, then sample 1 time unit later; tracks the last reset edge for the tick model.
  task automatic step();
    @(posedge clk100MHz);
    cyc++;
    if (reset) base = cyc;
    #1;
  endtask

  // n edges, each followed by a check of every output.
  task automatic seg(input int n, input int e_cnt, input int e_we, input int e_ocu, input int e_listo);
    for (int i = 0; i < n; i++) begin
      step();
      chk("contador", 32'(contador), 32'(e_cnt));
      chk("we",       32'(we),       32'(e_we));
      chk("ocupado",  32'(ocupado),  32'(e_ocu));
      chk("listo",    32'(listo),    32'(e_listo));
      chk("tick",     32'(tick),     32'((cyc != base) && ((cyc - base) % DIV == 0)));
    end
  endtask

  // A full pass from the first ESPERA-held cycle to FIN, given how many ESPERA cycles precede the first write.
  task automatic pass_body(input int wait0);
    seg(wait0, 0, 0, 1, 0);
    seg(1, 0, 3'b001, 1, 0);
    seg(3, 1, 0, 1, 0);
    seg(1, 1, 3'b010, 1, 0);
    seg(3, 2, 0, 1, 0);
    seg(1, 2, 3'b100, 1, 0);
    seg(1, 2, 0, 1, 1);
  endtask

  initial begin
    reset  = 1'b1;
    inicio = 1'b0;
    seg(2, 0, 0, 0, 0);
    reset = 1'b0;

    // Idle with prescaler running: ticks at base+4, +8, ...
    seg(20, 0, 0, 0, 0);

    // Single-cycle start; prescaler phase gives four ESPERA cycles before slot 0.
    inicio = 1'b1;
    seg(1, 0, 0, 1, 0);
    inicio = 1'b0;
    pass_body(3);
    seg(1, 0, 0, 0, 0);

    // inicio held: each pass ends in IDLE for one cycle, then restarts.
    inicio = 1'b1;
    pass_body(1);
    seg(1, 0, 0, 0, 0);
    pass_body(1);
    inicio = 1'b0;
    seg(2, 0, 0, 0, 0);

    // Re-pulses during ESPERA of slot 1 and during FIN are ignored.
    inicio = 1'b1;
    seg(1, 0, 0, 1, 0);
    inicio = 1'b0;
    seg(3, 0, 0, 1, 0);
    seg(1, 0, 3'b001, 1, 0);
    seg(1, 1, 0, 1, 0);
    inicio = 1'b1;
    seg(1, 1, 0, 1, 0);
    inicio = 1'b0;
    seg(1, 1, 0, 1, 0);
    seg(1, 1, 3'b010, 1, 0);
    seg(3, 2, 0, 1, 0);
    seg(1, 2, 3'b100, 1, 0);
    seg(1, 2, 0, 1, 1);
    inicio = 1'b1;
    seg(1, 0, 0, 0, 0);
    inicio = 1'b0;
    seg(3, 0, 0, 0, 0);

    // Reset right after the slot-1 write aborts the pass and restarts the prescaler.
    inicio = 1'b1;
    seg(1, 0, 0, 1, 0);
    inicio = 1'b0;
    seg(1, 0, 0, 1, 0);
    seg(1, 0, 3'b001, 1, 0);
    seg(3, 1, 0, 1, 0);
    seg(1, 1, 3'b010, 1, 0);
    reset = 1'b1;
    seg(1, 0, 0, 0, 0);
    reset = 1'b0;
    seg(12, 0, 0, 0, 0);

`ifdef CONTROL_SECUENCIA_AUTO_EN
    // Continuous passes while inicio is high; dropping it mid pass ends after that pass.
    inicio = 1'b1;
    pass_body(4);
    seg(2, 0, 0, 1, 0);
    seg(1, 0, 3'b001, 1, 0);
    inicio = 1'b0;
    seg(3, 1, 0, 1, 0);
    seg(1, 1, 3'b010, 1, 0);
    seg(3, 2, 0, 1, 0);
    seg(1, 2, 3'b100, 1, 0);
    seg(1, 2, 0, 1, 1);
    seg(2, 0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/control_secuencia_suma.md
Name: control_secuencia_suma

Overview:
- Sequencer for the coefficient-add datapath: coefficient mux select, adder, and a bank of output registers.
- On an `inicio` request it steps the coefficient index through all slots at a prescaled rate. For each slot it issues a one-cycle write enable to the matching output register, then reports `listo`.
- Runs entirely on `clk100MHz`. Uses an internal tick enable instead of a derived clock, so the register bank and sequencer share one clock domain.

Parameters:
- SLOTS, 3, number of coefficient/output-register slots (2..4)
- SEL_W, 2, width of the slot index `contador`; must satisfy 2**SEL_W >= SLOTS
- DIV, 666, prescaler period in `clk100MHz` cycles per tick (≈150 kHz); DIV >= 2

Ports:
- clk100MHz  input  1  system clock; the block's only clock
- reset  input  1  synchronous, active-high reset
- inicio  input  1  start request; level-sampled, accepted only in IDLE
- contador  output  SEL_W  slot index driving the coefficient mux select
- we  output  SLOTS  one-hot write enable to the output registers; we[i] loads slot i
- tick  output  1  prescaler pulse, one cycle every DIV cycles
- ocupado  output  1  sequence in progress
- listo  output  1  one-cycle pulse at sequence completion

Behaviour:
- Clocking: all state updates on the rising edge of `clk100MHz`. Reset is synchronous and active-high.
- Reset values: prescaler=0, tick=0, state=IDLE, contador=0, we=0, ocupado=0, listo=0.
- Prescaler: `pcnt` counts 0..DIV-1 and wraps to 0. It free-runs whenever reset=0 and is independent of state. `tick` is registered and is 1 in the cycle after pcnt==DIV-1, so the first tick after reset release comes DIV cycles later.
- States: IDLE, ESPERA, ESCRIBE, FIN.
- IDLE: ocupado=0, we=0.
  - If inicio=1, go to ESPERA next cycle with contador=0 and ocupado=1.
- ESPERA: ocupado=1; contador is held stable so the mux and adder output settle.
  - If tick=1, go to ESCRIBE.
  - If tick=0, stay.
- ESCRIBE (exactly one cycle): we[contador]=1 and all other bits 0; ocupado=1.
  - If contador==SLOTS-1, go to FIN and hold contador.
  - Otherwise contador+1 and go to ESPERA.
- FIN (exactly one cycle): listo=1, we=0, ocupado=1; next state IDLE, contador=0.
- we and listo are registered outputs. They are never asserted outside ESCRIBE and FIN respectively.
- Timing: exactly SLOTS write pulses per accepted start, in slot order 0..SLOTS-1. Consecutive we pulses are spaced exactly DIV cycles apart. The first we pulse lands 1..DIV cycles after ESPERA entry, depending on prescaler phase.
- inicio while ocupado=1 (including the FIN cycle) is ignored and not queued. The earliest re-start is inicio sampled in the IDLE cycle after FIN.
- A tick during ESCRIBE or FIN is not consumed. The next tick is DIV cycles later.
- Reset asserted mid-sequence: reset values at the next edge, no further we or listo, and the prescaler restarts at 0.
- contador never exceeds SLOTS-1.

Optional Feature:
- Macro: CONTROL_SECUENCIA_AUTO_EN
- Defined: FIN goes directly to ESPERA with contador=0 and ocupado stays 1, so the sequence repeats continuously with listo pulsed once per pass. Returning to IDLE after FIN requires inicio=0 sampled in FIN.
- Undefined: single-shot behaviour as above; inicio level has no effect in FIN.

Test Plan (DIV=4, SLOTS=3):
- Reset release, inicio=0 for 20 cycles -> tick pulses every 4 cycles; contador=0, we=0, ocupado=0, listo=0 throughout.
- inicio pulsed 1 cycle in IDLE -> we sequence 3'b001, 3'b010, 3'b100, each one cycle, 4 cycles apart; contador 0→1→2; one listo pulse the cycle after we=3'b100, then ocupado=0.
- inicio held high continuously (macro undefined) -> sequence restarts from contador=0 in the IDLE cycle after FIN; every pass produces exactly 3 we pulses and 1 listo.
- inicio re-pulsed during ESPERA of slot 1 and during FIN -> no extra we pulses, no contador change, single listo.
- reset=1 for one cycle right after we=3'b010 -> next cycle all outputs at reset values; no we=3'b100 or listo follows without a new inicio.
- CONTROL_SECUENCIA_AUTO_EN defined, inicio=1 then dropped mid second pass -> second pass completes with listo, block returns to IDLE, ocupado=0.
